// File: rtl/shift_add_mult.sv
// 4x4 unsigned shift-and-add multiplier (IDLE/CALC/DONE) with ripple-carry accumulate.
// Define MULT_EARLY_DONE_EN to leave CALC as soon as no multiplier bits remain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module shift_add_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  acc, mcand, addend, sum;
  logic [3:0]  mplier;
  logic [1:0]  cnt;
  logic [7:0]  carry;
  logic        carry_unused;
  logic        last;

  assign addend   = mplier[0] ? mcand : 8'd0;
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < 7; gi++) begin : g_fa
    full_adder u_fa (
      .x (acc[gi]),
      .y (addend[gi]),
      .ci(carry[gi]),
      .s (sum[gi]),
      .co(carry[gi+1])
    );
  end

  // Carry out of bit 7 is dropped: the product never exceeds 8 bits.
  full_adder u_fa_msb (
    .x (acc[7]),
    .y (addend[7]),
    .ci(carry[7]),
    .s (sum[7]),
    .co(carry_unused)
  );

`ifdef MULT_EARLY_DONE_EN
  assign last = (cnt == 2'd3) || (mplier[3:1] == 3'd0);
`else
  assign last = (cnt == 2'd3);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p      <= 8'd0;
      acc    <= 8'd0;
      mcand  <= 8'd0;
      mplier <= 4'd0;
      cnt    <= 2'd0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          mcand  <= {4'd0, a};
          mplier <= b;
          acc    <= 8'd0;
          cnt    <= 2'd0;
        end
        CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 2'd1;
          if (last) p <= sum;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: timeline model plus directed vectors.
// Checks busy/done/p every cycle against an operation schedule derived from a*b.
module tb_shift_add_mult;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] p;

  int checks = 0;
  int errors = 0;

  shift_add_mult dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  always #5 clk = ~clk;

  // Model: an accepted op at edge k gives busy after edges k..k+n-1,
  // done after edge k+n, p = a*b from edge k+n; next accept at k+n+2.
  int         cyc = 0;
  int         free_at = 0;
  int         op_k = -100;
  int         op_n = 0;
  logic [7:0] op_prod = 8'd0;
  logic [7:0] exp_p = 8'd0;
  logic       has_op = 1'b0;
  logic       model_ok = 1'b0;

  function automatic int calc_len(input logic [3:0] bb);
`ifdef MULT_EARLY_DONE_EN
    if (bb == 4'd0) return 1;
    return $clog2(int'(bb) + 1);
`else
    return 4;
`endif
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      has_op   = 1'b0;
      exp_p    = 8'd0;
      free_at  = cyc;
      model_ok = 1'b1;
    end else begin
      if (cyc >= free_at && start) begin
        has_op  = 1'b1;
        op_k    = cyc;
        op_n    = calc_len(b);
        op_prod = 8'(int'(a) * int'(b));
        free_at = cyc + op_n + 2;
      end
      if (has_op && cyc == op_k + op_n) exp_p = op_prod;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy", int'(busy),
          int'(has_op && cyc >= op_k && cyc <= op_k + op_n - 1));
      chk("done", int'(done), int'(has_op && cyc == op_k + op_n));
      chk("p", int'(p), int'(exp_p));
    end
  end

  // Issue one op from IDLE; report busy cycles and product at the done pulse.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        output int nbusy, output logic [7:0] pv);
    int t;
    nbusy = 0;
    pv    = 8'd0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;
    t = 0;
    while (!done && t < 12) begin
      if (busy) nbusy++;
      @(negedge clk);
      t++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done for a=%0d b=%0d", av, bv);
    end
    pv = p;
    @(negedge clk);
  endtask

  int         nb;
  logic [7:0] pv;
  int         dcount;

  initial begin
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_p", int'(p), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    run_op(4'hF, 4'hF, nb, pv);
    chk("ff_p", int'(pv), 225);
    chk("ff_busy_cycles", nb, 4);

    for (int i = 0; i < 256; i++) begin
      run_op(4'(i >> 4), 4'(i), nb, pv);
      checks++;
      if (pv != 8'((i >> 4) * (i & 15))) begin
        errors++;
        $display("FAIL sweep a=%0d b=%0d: got %0d", i >> 4, i & 15, pv);
      end
    end

    // Second start during CALC must be ignored.
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignore_p", int'(p), 15);

    // Reset at the 2nd CALC edge aborts the op.
    @(negedge clk);
    a = 4'd9; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_p", int'(p), 0);
    chk("abort_busy", int'(busy), 0);
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);

`ifdef MULT_EARLY_DONE_EN
    run_op(4'd9, 4'd0, nb, pv);
    chk("early_b0_p", int'(pv), 0);
    chk("early_b0_n", nb, 1);
    run_op(4'd5, 4'd2, nb, pv);
    chk("early_52_p", int'(pv), 10);
    chk("early_52_n", nb, 2);
    run_op(4'd5, 4'd8, nb, pv);
    chk("early_58_p", int'(pv), 40);
    chk("early_58_n", nb, 4);
`else
    run_op(4'd9, 4'd0, nb, pv);
    chk("b0_p", int'(pv), 0);
    chk("b0_n", nb, 4);
`endif

    // Start held high: back-to-back ops with one IDLE cycle between.
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        chk("held_p", int'(p), 6);
      end
    end
    start = 1'b0;
    chk("held_count", dcount, (calc_len(4'd3) == 4) ? 3 : 5);
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, rising-edge clock for all state.
REQ-002 rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-004 a, input, 4, unsigned multiplicand; latched when start is accepted.
REQ-005 b, input, 4, unsigned multiplier; latched when start is accepted.
REQ-006 busy, output, 1, high while in CALC.
REQ-007 done, output, 1, one-cycle pulse in DONE; p is valid while done is high.
REQ-008 p, output, 8, unsigned product; holds its last value until the next accepted start.

Function
REQ-009 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-010 IDLE with start=1 at an edge -> CALC; latch a into mcand[7:0] (zero-extended) and b into mplier[3:0]; clear acc[7:0] and cnt[1:0].
REQ-011 Each CALC edge: if mplier[0]=1, acc <= acc + mcand (8-bit, no carry out); mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
REQ-012 The add SHALL be a ripple adder built from full_adder instances (cin of bit 0 = 0).
REQ-013 CALC -> DONE on the edge that processes the 4th bit (cnt=3); the early-exit condition is in REQ-023.
REQ-014 On CALC -> DONE, p SHALL load the final acc value; done=1 for exactly the one cycle spent in DONE; DONE -> IDLE unconditionally on the next edge.
REQ-015 Baseline latency: start accepted at edge k -> done high during the cycle after edge k+4; p updates at edge k+4.
REQ-016 start is ignored in CALC and DONE: no restart, and a, b and acc are unaffected.
REQ-017 start held high continuously SHALL produce back-to-back operations with one IDLE cycle between them.
REQ-018 a and b may change freely after acceptance without affecting the result.
REQ-019 The result SHALL be exact for all 256 operand pairs; maximum 15*15=225 fits in 8 bits.

Reset
REQ-020 While rst=1 at an edge: state <= IDLE; p <= 0; done <= 0; busy <= 0; acc, mcand, mplier and cnt <= 0.
REQ-021 rst takes priority over start and over any CALC/DONE activity; reset mid-operation aborts it with no done pulse.
REQ-022 The first start is accepted at the first edge where rst=0 and start=1.

Configuration
REQ-023 When macro MULT_EARLY_DONE_EN is defined, CALC -> DONE SHALL also occur on any CALC edge whose post-shift mplier equals 0.
- Resulting latency is n = max(1, index of the highest set bit of b + 1) CALC cycles.
- b=0 gives n=1 and p=0.
REQ-024 When MULT_EARLY_DONE_EN is undefined, CALC always lasts exactly 4 cycles (REQ-015); results are identical in both builds.

Verification
REQ-025 Reset, then a=0xF, b=0xF, 1-cycle start -> busy high 4 cycles, done pulse 1 cycle, p=0xE1 (225).
REQ-026 Exhaustive sweep of 256 (a,b) pairs, one start per pair -> every p equals a*b and exactly one done pulse per start.
REQ-027 a=3, b=5 accepted; then start pulsed with a=7, b=7 during CALC -> the second start is ignored and p=0x0F.
REQ-028 a=9, b=6 accepted; rst asserted at the 2nd CALC edge -> next cycle is IDLE with p=0, done=0, and no done pulse afterwards.
REQ-029 With MULT_EARLY_DONE_EN: b=0 -> done after 1 CALC cycle with p=0; a=5, b=2 -> 2 CALC cycles with p=10; a=5, b=8 -> 4 CALC cycles with p=40.
REQ-030 start held high, a=2, b=3 -> repeating pattern CALC×4, DONE, IDLE; p=6 on every done pulse.
